mtm_alu_serial_n: RTL and testbench

- Parametrised successor to the serial mtm ALU.
- Receives an operand/command frame on a one-wire serial input, checks it, and executes an N-byte ALU operation.
- Returns the result, or an error packet, on a one-wire serial output.
- Adds over the previous generation: configurable operand width, XOR operation, an inter-packet watchdog and a busy indicator.

---
 rtl/mtm_alu_serial_n.sv | 226 ++++++++++++++++++++++
 tb/tb_mtm_alu_serial_n.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_serial_n.sv
// Serial-framed N-byte ALU: receives B, A and a command over one wire, checks the
// frame, and returns either the result with flags or a single error packet.
module mtm_alu_serial_n #(
  parameter int N_BYTES     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sin,
  output logic sout,
  output logic busy
);

  localparam int W    = 8 * N_BYTES;
  localparam int NPKT = 2 * N_BYTES;
  localparam int TXW  = 11 * (N_BYTES + 1);
  localparam int GW   = $clog2(TIMEOUT_CYC + 1);
  localparam int TCW  = $clog2(TXW + 1);
  localparam int DCW  = $clog2(NPKT + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_TYPE, S_PAYLOAD, S_STOP, S_GAP, S_EXEC, S_TX, S_DRAIN
  } state_t;

  state_t           state_q;
  logic [2:0]       bit_cnt_q;
  logic [DCW-1:0]   dcnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [3:0]       drain_cnt_q;
  logic [TCW-1:0]   tx_left_q;
  logic             type_q;
  logic             sout_q;
  logic             busy_q;
  logic [2:0]       err_q;
  logic [7:0]       rx_sh_q;
  logic [2*W-1:0]   data_q;
  logic [TXW-1:0]   tx_q;

  logic [W-1:0]        b_w, a_w, c_w;
  logic signed [W-1:0] b_s, a_s, c_s;
  logic [W:0]          sum_w, dif_w;
  logic [2:0]          op_w;
  logic [3:0]          flags_w;
  logic                carry_w, ovf_w, op_bad, crc_bad;
  logic                exec_go, drain_go;

  function automatic logic [3:0] crc4_calc(input logic [2*W+3:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 2*W+3; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [2:0] crc3_calc(input logic [W+4:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = W+4; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  function automatic logic [TXW-1:0] build_ok(input logic [W-1:0] c, input logic [3:0] fl);
    logic [TXW-1:0] v;
    v = '1;
    for (int i = 0; i < N_BYTES; i++)
      v[TXW-1-11*i -: 11] = {2'b00, c[W-1-8*i -: 8], 1'b1};
    v[10:0] = {2'b01, 1'b0, fl, crc3_calc({c, 1'b0, fl}), 1'b1};
    return v;
  endfunction

  function automatic logic [7:0] err_payload(input logic [2:0] e);
    return {1'b1, e, e, ^{1'b1, e, e}};
  endfunction

  always_comb begin
    b_w     = data_q[2*W-1:W];
    a_w     = data_q[W-1:0];
    op_w    = rx_sh_q[6:4];
    sum_w   = {1'b0, b_w} + {1'b0, a_w};
    dif_w   = {1'b0, b_w} - {1'b0, a_w};
    c_w     = '0;
    carry_w = 1'b0;
    ovf_w   = 1'b0;
    op_bad  = 1'b0;
    case (op_w)
      OP_AND: c_w = b_w & a_w;
      OP_OR:  c_w = b_w | a_w;
      OP_XOR: c_w = b_w ^ a_w;
      OP_ADD: begin c_w = sum_w[W-1:0]; carry_w = sum_w[W]; end
      OP_SUB: begin c_w = dif_w[W-1:0]; carry_w = dif_w[W]; end
      default: op_bad = 1'b1;
    endcase
    b_s = $signed(b_w);
    a_s = $signed(a_w);
    c_s = $signed(c_w);
    if (op_w == OP_ADD)
      ovf_w = ((b_s < 0) == (a_s < 0)) && ((c_s < 0) != (b_s < 0));
    else if (op_w == OP_SUB)
      ovf_w = ((b_s < 0) != (a_s < 0)) && ((c_s < 0) != (b_s < 0));
    flags_w  = {carry_w, ovf_w, (c_w == '0), c_w[W-1]};
    crc_bad  = (crc4_calc({b_w, a_w, 1'b1, op_w}) != rx_sh_q[3:0]);
    exec_go  = (state_q == S_EXEC) && !crc_bad && !op_bad;
    drain_go = (state_q == S_DRAIN) && sin && (drain_cnt_q == 4'd10);
  end

  // Control FSM: framing, packet counting, watchdog, error drain and TX pacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      dcnt_q      <= '0;
      gap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      tx_left_q   <= '0;
      type_q      <= 1'b0;
      sout_q      <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (!sin) begin
          state_q <= S_TYPE;
          busy_q  <= 1'b1;
          dcnt_q  <= '0;
        end
        S_TYPE: begin
          type_q    <= sin;
          bit_cnt_q <= '0;
          state_q   <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= S_STOP;
        end
        S_STOP: begin
          gap_cnt_q   <= '0;
          drain_cnt_q <= '0;
          if (!sin || (type_q ? (dcnt_q != DCW'(NPKT)) : (dcnt_q == DCW'(NPKT)))) begin
            err_q   <= 3'b100;
            state_q <= S_DRAIN;
          end else if (type_q) begin
            state_q <= S_EXEC;
          end else begin
            dcnt_q  <= dcnt_q + DCW'(1);
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (!sin) begin
            gap_cnt_q <= '0;
            state_q   <= S_TYPE;
          end else if (gap_cnt_q == GW'(TIMEOUT_CYC - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        S_EXEC: begin
          drain_cnt_q <= '0;
          if (crc_bad) begin
            err_q   <= 3'b010;
            state_q <= S_DRAIN;
          end else if (op_bad) begin
            err_q   <= 3'b001;
            state_q <= S_DRAIN;
          end else begin
            tx_left_q <= TCW'(TXW);
            state_q   <= S_TX;
          end
        end
        S_DRAIN: begin
          if (!sin) begin
            drain_cnt_q <= '0;
          end else if (drain_go) begin
            tx_left_q <= TCW'(11);
            state_q   <= S_TX;
          end else begin
            drain_cnt_q <= drain_cnt_q + 4'd1;
          end
        end
        S_TX: begin
          if (tx_left_q != '0) begin
            sout_q    <= tx_q[TXW-1];
            tx_left_q <= tx_left_q - TCW'(1);
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: receive shifter, operand store, transmit shifter
  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD)
      rx_sh_q <= {rx_sh_q[6:0], sin};
    if (state_q == S_STOP && !type_q && sin)
      data_q <= {data_q[2*W-9:0], rx_sh_q};
    if (exec_go)
      tx_q <= build_ok(c_w, flags_w);
    else if (drain_go)
      tx_q <= {2'b01, err_payload(err_q), 1'b1, {(TXW-11){1'b1}}};
    else if (state_q == S_TX)
      tx_q <= {tx_q[TXW-2:0], 1'b1};
  end

  assign sout = sout_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mtm_alu_serial_n.sv
// Scoreboard bench for mtm_alu_serial_n: stimulus pushes expected packets,
// per-instance monitors decode sout and compare.
`timescale 1ns/1ps
module tb_mtm_alu_serial_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n4 = 1'b1, rst_n1 = 1'b1;
  logic sin4 = 1'b1, sin1 = 1'b1;
  logic sout4, busy4, sout1, busy1;

  mtm_alu_serial_n #(.N_BYTES(4), .TIMEOUT_CYC(64)) dut4 (
    .clk(clk), .rst_n(rst_n4), .sin(sin4), .sout(sout4), .busy(busy4));
  mtm_alu_serial_n #(.N_BYTES(1), .TIMEOUT_CYC(64)) dut1 (
    .clk(clk), .rst_n(rst_n1), .sin(sin1), .sout(sout1), .busy(busy1));

  int checks = 0;
  int failures = 0;
  logic [9:0] q4[$];
  logic [9:0] q1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of msg(x)*x^k divided by poly, by explicit long division.
  function automatic logic [3:0] crc_rem(input logic [127:0] msg, input int len,
                                         input int k, input logic [4:0] poly);
    bit r[136];
    logic [3:0] res;
    for (int i = 0; i < 136; i++) r[i] = 1'b0;
    for (int i = 0; i < len; i++) r[i] = msg[len-1-i];
    for (int i = 0; i < len; i++)
      if (r[i]) for (int j = 0; j <= k; j++) r[i+j] ^= poly[k-j];
    res = '0;
    for (int j = 0; j < k; j++) res = {res[2:0], r[len+j]};
    return res;
  endfunction

  task automatic monitor(input int w);
    logic [9:0] pkt;
    logic [9:0] exp;
    bit abort;
    forever begin
      @(negedge clk);
      if ((w == 1 ? rst_n1 : rst_n4) && ((w == 1 ? sout1 : sout4) == 1'b0)) begin
        pkt = '0;
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!(w == 1 ? rst_n1 : rst_n4)) begin abort = 1'b1; break; end
          pkt = {pkt[8:0], (w == 1 ? sout1 : sout4)};
        end
        if (!abort) begin
          if ((w == 1 ? q1.size() : q4.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pkt_n%0d: got %0h expected no packet", (w == 1 ? 1 : 4), pkt);
          end else begin
            exp = (w == 1) ? q1.pop_front() : q4.pop_front();
            check((w == 1) ? "pkt_n1" : "pkt_n4", {54'd0, pkt}, {54'd0, exp});
          end
        end
      end
    end
  endtask

  task automatic send_bit(input int w, input logic b);
    if (w == 1) sin1 = b; else sin4 = b;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int w, input logic typ, input logic [7:0] pl, input logic stopb);
    send_bit(w, 1'b0);
    send_bit(w, typ);
    for (int i = 7; i >= 0; i--) send_bit(w, pl[i]);
    send_bit(w, stopb);
  endtask

  task automatic idle_gap(input int w, input int n);
    if (w == 1) sin1 = 1'b1; else sin4 = 1'b1;
    repeat (n) @(negedge clk);
    if (n > 0 && n < 64) check("busy_in_gap", {63'd0, (w == 1 ? busy1 : busy4)}, 64'd1);
  endtask

  task automatic send_frame(input int w, input int nb, input logic [63:0] b, input logic [63:0] a,
                            input logic [2:0] op, input logic [3:0] crc_x,
                            input int bad_stop, input int gap_at, input int gap_len);
    logic [127:0] msg;
    logic [3:0] crc;
    int k;
    msg = '0;
    for (int i = 8*nb-1; i >= 0; i--) msg = {msg[126:0], b[i]};
    for (int i = 8*nb-1; i >= 0; i--) msg = {msg[126:0], a[i]};
    msg = {msg[123:0], 1'b1, op};
    crc = crc_rem(msg, 16*nb+4, 4, 5'b10011) ^ crc_x;
    k = 0;
    for (int i = nb-1; i >= 0; i--) begin
      send_pkt(w, 1'b0, b[8*i +: 8], k != bad_stop);
      if (k == gap_at) idle_gap(w, gap_len);
      k++;
    end
    for (int i = nb-1; i >= 0; i--) begin
      send_pkt(w, 1'b0, a[8*i +: 8], k != bad_stop);
      if (k == gap_at) idle_gap(w, gap_len);
      k++;
    end
    send_pkt(w, 1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic expect_ok(input int w, input int nb, input logic [63:0] c, input logic [3:0] fl);
    logic [127:0] msg;
    logic [3:0] crc3;
    msg = '0;
    for (int i = 8*nb-1; i >= 0; i--) msg = {msg[126:0], c[i]};
    msg = {msg[122:0], 1'b0, fl};
    crc3 = crc_rem(msg, 8*nb+5, 3, 5'b01011);
    for (int i = nb-1; i >= 0; i--) begin
      if (w == 1) q1.push_back({1'b0, c[8*i +: 8], 1'b1});
      else        q4.push_back({1'b0, c[8*i +: 8], 1'b1});
    end
    if (w == 1) q1.push_back({2'b10, fl, crc3[2:0], 1'b1});
    else        q4.push_back({2'b10, fl, crc3[2:0], 1'b1});
  endtask

  task automatic expect_err(input int w, input logic [7:0] pl);
    if (w == 1) q1.push_back({1'b1, pl, 1'b1});
    else        q4.push_back({1'b1, pl, 1'b1});
  endtask

  task automatic wait_done(input int w, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (w == 1) ? (!busy1 && q1.size() == 0) : (!busy4 && q4.size() == 0);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: frame not completed, busy still set or packets outstanding", name);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic allhigh;
    int found;
    #1;
    rst_n4 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sout4", {63'd0, sout4}, 64'd1);
    check("reset_busy4", {63'd0, busy4}, 64'd0);
    check("reset_sout1", {63'd0, sout1}, 64'd1);
    check("reset_busy1", {63'd0, busy1}, 64'd0);
    rst_n4 = 1'b1;
    rst_n1 = 1'b1;
    repeat (2) @(negedge clk);
    fork
      monitor(0);
      monitor(1);
    join_none

    // SUB with borrow, plus output latency
    expect_ok(0, 4, 64'hFFFFFFFF, 4'b1001);
    send_frame(0, 4, 64'h1, 64'h2, 3'b101, 4'h0, -1, -1, 0);
    check("lat_t0_sout", {63'd0, sout4}, 64'd1);
    @(negedge clk);
    check("lat_t1_sout", {63'd0, sout4}, 64'd1);
    @(negedge clk);
    check("lat_t2_sout", {63'd0, sout4}, 64'd0);
    wait_done(0, "sub_borrow");

    expect_ok(0, 4, 64'h80000000, 4'b0101);
    send_frame(0, 4, 64'h7FFFFFFF, 64'h1, 3'b100, 4'h0, -1, -1, 0);
    wait_done(0, "add_ovf");
    expect_ok(0, 4, 64'h0, 4'b0010);
    send_frame(0, 4, 64'hA5A5A5A5, 64'hA5A5A5A5, 3'b010, 4'h0, -1, -1, 0);
    wait_done(0, "xor_zero");
    expect_ok(0, 4, 64'hF0001200, 4'b0001);
    send_frame(0, 4, 64'hF0F01234, 64'hFF00FF00, 3'b000, 4'h0, -1, -1, 0);
    wait_done(0, "and");
    expect_ok(0, 4, 64'h000000FF, 4'b0000);
    send_frame(0, 4, 64'hF0, 64'h0F, 3'b001, 4'h0, -1, -1, 0);
    wait_done(0, "or");
    expect_ok(0, 4, 64'h7FFFFFFF, 4'b0100);
    send_frame(0, 4, 64'h80000000, 64'h1, 3'b101, 4'h0, -1, -1, 0);
    wait_done(0, "sub_ovf");

    // Error packets
    expect_err(0, 8'hA5);
    send_frame(0, 4, 64'h3, 64'h5, 3'b000, 4'h1, -1, -1, 0);
    wait_done(0, "err_crc");
    expect_err(0, 8'h93);
    send_frame(0, 4, 64'h3, 64'h5, 3'b110, 4'h0, -1, -1, 0);
    wait_done(0, "err_op");
    expect_err(0, 8'hC9);
    for (int i = 0; i < 3; i++) send_pkt(0, 1'b0, 8'h11, 1'b1);
    send_pkt(0, 1'b1, 8'h40, 1'b1);
    wait_done(0, "err_short");
    expect_err(0, 8'hC9);
    send_frame(0, 4, 64'h3, 64'h5, 3'b100, 4'h0, 0, -1, 0);
    wait_done(0, "err_stop0");
    expect_err(0, 8'hC9);
    for (int i = 0; i < 9; i++) send_pkt(0, 1'b0, 8'h22, 1'b1);
    send_pkt(0, 1'b1, 8'h40, 1'b1);
    wait_done(0, "err_long");

    // Watchdog: 64 idle cycles discards, 63 is tolerated
    for (int i = 0; i < 4; i++) send_pkt(0, 1'b0, 8'h55, 1'b1);
    allhigh = 1'b1;
    repeat (64) begin
      @(negedge clk);
      allhigh &= sout4;
    end
    check("wdog_sout_idle", {63'd0, allhigh}, 64'd1);
    check("wdog_busy_low", {63'd0, busy4}, 64'd0);
    expect_ok(0, 4, 64'h000000FF, 4'b0000);
    send_frame(0, 4, 64'hF0, 64'h0F, 3'b001, 4'h0, -1, -1, 0);
    wait_done(0, "after_wdog");
    expect_ok(0, 4, 64'h00000003, 4'b0000);
    send_frame(0, 4, 64'h1, 64'h2, 3'b100, 4'h0, -1, 3, 63);
    wait_done(0, "gap63");

    // N_BYTES = 1 instance
    expect_ok(1, 1, 64'h00, 4'b1010);
    send_frame(1, 1, 64'hFF, 64'h01, 3'b100, 4'h0, -1, -1, 0);
    wait_done(1, "n1_add_carry");

    expect_ok(1, 1, 64'h02, 4'b0000);
    send_frame(1, 1, 64'h05, 64'h03, 3'b101, 4'h0, -1, -1, 0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (sout1 == 1'b0) found = 1;
    end
    check("n1_tx_started", found, 1);
    repeat (5) @(negedge clk);
    #2;
    rst_n1 = 1'b0;
    q1.delete();
    #1;
    check("rst_mid_tx_sout", {63'd0, sout1}, 64'd1);
    check("rst_mid_tx_busy", {63'd0, busy1}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n1 = 1'b1;
    allhigh = 1'b1;
    repeat (30) begin
      @(negedge clk);
      allhigh &= sout1 & ~busy1;
    end
    check("rst_no_resume", {63'd0, allhigh}, 64'd1);
    expect_ok(1, 1, 64'hFF, 4'b0001);
    send_frame(1, 1, 64'h0F, 64'hF0, 3'b001, 4'h0, -1, -1, 0);
    wait_done(1, "n1_after_rst");

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
